// File: rtl/float_pkg.sv
// Shared definitions for the pipelined floating-point multiplier: default
// format widths, exponent bias helper, packed word layout and flag bit indices.
package float_pkg;

  localparam int unsigned FP_EXP_W = 7;
  localparam int unsigned FP_MAN_W = 16;
  localparam int unsigned FP_TAG_W = 4;

  localparam int unsigned FLAG_UF = 0;
  localparam int unsigned FLAG_OF = 1;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] expo;
    logic [FP_MAN_W-1:0] man;
  } fp_word_t;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/float_mul_norm.sv
// Combinational normalise-and-round stage of float_mul_pipe.
// Rounding is round-to-nearest-even when FMUL_RNE_EN is defined, truncation otherwise.
module float_mul_norm
  import float_pkg::*;
#(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W
) (
  input  logic [2*MAN_W+1:0]       prod,
  input  logic signed [EXP_W+1:0]  exp_in,
  output logic [MAN_W-1:0]         man_out,
  output logic signed [EXP_W+1:0]  exp_out
);

  localparam int unsigned PW = 2*MAN_W + 2;
  localparam int unsigned SW = EXP_W + 2;

  logic [MAN_W:0]          mant;
  logic                    guard;
  logic                    sticky;
  logic signed [SW-1:0]    exp_n;

  // Product of two [1,2) significands lies in [1,4); bit PW-1 flags the [2,4) case.
  always_comb begin
    mant   = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    exp_n  = exp_in;
    if (prod[PW-1]) begin
      mant   = prod[PW-1 -: MAN_W+1];
      guard  = prod[PW-MAN_W-2];
      sticky = |prod[PW-MAN_W-3:0];
      exp_n  = exp_in + SW'(1);
    end else begin
      mant   = prod[PW-2 -: MAN_W+1];
      guard  = prod[PW-MAN_W-3];
      sticky = |prod[PW-MAN_W-4:0];
    end
  end

`ifdef FMUL_RNE_EN
  logic             round_up;
  logic [MAN_W+1:0] sum;

  assign round_up = guard & (sticky | mant[0]);
  assign sum      = {1'b0, mant} + (MAN_W+2)'(round_up);

  // Carry out of 1.111..1 + ulp gives 10.000..0: mantissa wraps to zero.
  always_comb begin
    man_out = sum[MAN_W-1:0];
    exp_out = exp_n;
    if (sum[MAN_W+1]) begin
      man_out = sum[MAN_W:1];
      exp_out = exp_n + SW'(1);
    end
  end
`else
  logic trunc_unused;

  assign trunc_unused = guard ^ sticky ^ mant[MAN_W];
  assign man_out      = mant[MAN_W-1:0];
  assign exp_out      = exp_n;
`endif

endmodule

// File: rtl/float_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake,
// tag pass-through and sticky flags. FMUL_RNE_EN selects round-to-nearest-even.
module float_mul_pipe
  import float_pkg::*;
#(
  parameter int unsigned EXP_W = FP_EXP_W,
  parameter int unsigned MAN_W = FP_MAN_W,
  parameter int unsigned TAG_W = FP_TAG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   float_a,
  input  logic [EXP_W+MAN_W:0]   float_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   float_out,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   float_out_underflow,
  output logic                   float_out_overflow,
  output logic [1:0]             sticky_flags,
  input  logic                   flag_clr
);

  localparam int unsigned PW = 2*MAN_W + 2;
  localparam int unsigned SW = EXP_W + 2;
  localparam logic signed [SW-1:0] BIAS    = SW'(fp_bias(EXP_W));
  localparam logic signed [SW-1:0] EXP_MAX = SW'((32'd1 << EXP_W) - 32'd1);
  localparam logic signed [SW-1:0] EXP_MIN = SW'(1);

  // Stage 1: unpack, zero detect, exponent sum, significand product
  logic [EXP_W-1:0]     ea, eb;
  logic                 s1_valid, s1_sign, s1_zero;
  logic signed [SW-1:0] s1_exp;
  logic [PW-1:0]        s1_prod;
  logic [TAG_W-1:0]     s1_tag;

  // Stage 2: normalised and rounded
  logic                 s2_valid, s2_sign, s2_zero;
  logic signed [SW-1:0] s2_exp;
  logic [MAN_W-1:0]     s2_man;
  logic [TAG_W-1:0]     s2_tag;

  logic [MAN_W-1:0]     norm_man;
  logic signed [SW-1:0] norm_exp;

  logic [EXP_W+MAN_W:0] pack_word;
  logic                 pack_uf, pack_of;

  logic s3_load, s2_adv, s2_load, s1_adv;

  assign ea = float_a[MAN_W +: EXP_W];
  assign eb = float_b[MAN_W +: EXP_W];

  // Each stage refills when empty or when its occupant moves on this cycle.
  assign s3_load  = !out_valid || out_ready;
  assign s2_adv   = s2_valid && s3_load;
  assign s2_load  = !s2_valid || s2_adv;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = !s1_valid || s1_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_exp   <= '0;
      s1_prod  <= '0;
      s1_tag   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= float_a[EXP_W+MAN_W] ^ float_b[EXP_W+MAN_W];
        s1_zero <= (ea == '0) || (eb == '0);
        s1_exp  <= SW'(ea) + SW'(eb) - BIAS;
        s1_prod <= PW'({1'b1, float_a[MAN_W-1:0]}) * PW'({1'b1, float_b[MAN_W-1:0]});
        s1_tag  <= in_tag;
      end
    end
  end

  float_mul_norm #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_norm (
    .prod    (s1_prod),
    .exp_in  (s1_exp),
    .man_out (norm_man),
    .exp_out (norm_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_exp   <= '0;
      s2_man   <= '0;
      s2_tag   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_zero <= s1_zero;
        s2_exp  <= norm_exp;
        s2_man  <= norm_man;
        s2_tag  <= s1_tag;
      end
    end
  end

  always_comb begin
    pack_word = '0;
    pack_uf   = 1'b0;
    pack_of   = 1'b0;
    if (s2_zero) begin
      pack_word = '0;
    end else if (s2_exp > EXP_MAX) begin
      pack_word = {s2_sign, {(EXP_W+MAN_W){1'b1}}};
      pack_of   = 1'b1;
    end else if (s2_exp < EXP_MIN) begin
      pack_uf   = 1'b1;
    end else begin
      pack_word = {s2_sign, s2_exp[EXP_W-1:0], s2_man};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid           <= 1'b0;
      float_out           <= '0;
      out_tag             <= '0;
      float_out_underflow <= 1'b0;
      float_out_overflow  <= 1'b0;
    end else if (s3_load) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        float_out           <= pack_word;
        out_tag             <= s2_tag;
        float_out_underflow <= pack_uf;
        float_out_overflow  <= pack_of;
      end
    end
  end

  // Events are recorded as results leave; a simultaneous clear discards them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (flag_clr) begin
      sticky_flags <= '0;
    end else if (out_valid && out_ready) begin
      sticky_flags[FLAG_UF] <= sticky_flags[FLAG_UF] | float_out_underflow;
      sticky_flags[FLAG_OF] <= sticky_flags[FLAG_OF] | float_out_overflow;
    end
  end

endmodule

// File: tb/tb_float_mul_pipe.sv
// Directed self-checking bench for float_mul_pipe (default 1/7/16 format).
// Rounding expectations follow FMUL_RNE_EN when it is defined for the build.
module tb_float_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] float_a, float_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] float_out;
  logic [3:0]  out_tag;
  logic        float_out_underflow;
  logic        float_out_overflow;
  logic [1:0]  sticky_flags;
  logic        flag_clr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  float_mul_pipe #(
    .EXP_W (7),
    .MAN_W (16),
    .TAG_W (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .float_a             (float_a),
    .float_b             (float_b),
    .in_tag              (in_tag),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .float_out           (float_out),
    .out_tag             (out_tag),
    .float_out_underflow (float_out_underflow),
    .float_out_overflow  (float_out_overflow),
    .sticky_flags        (sticky_flags),
    .flag_clr            (flag_clr)
  );

  task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic [3:0] t,
                       output logic ok);
    float_a  = a;
    float_b  = b;
    in_tag   = t;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = out_valid;
    end
  endtask

  task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic [3:0] t,
                        output logic [23:0] r, output logic [3:0] rt,
                        output logic uf, output logic of, output logic ok);
    logic ok_in, ok_out;
    issue(a, b, t, ok_in);
    wait_out(ok_out);
    r  = float_out;
    rt = out_tag;
    uf = float_out_underflow;
    of = float_out_overflow;
    @(posedge clk);
    #1;
    ok = ok_in && ok_out;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    tests++;
    if ({out_valid, float_out, out_tag, float_out_underflow, float_out_overflow, sticky_flags} !== '0) begin
      fails++;
      $display("FAIL reset_state: got valid=%b out=%h tag=%h uf=%b of=%b sticky=%b expected all zero",
               out_valid, float_out, out_tag, float_out_underflow, float_out_overflow, sticky_flags);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic;
    logic [23:0] r;
    logic [3:0]  rt;
    logic        uf, of, ok;
    float_a  = 24'h469040;
    float_b  = 24'h3D8000;
    in_tag   = 4'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL latency_early: got out_valid=%b expected 0", out_valid);
    end
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL latency_due: got out_valid=%b expected 1", out_valid);
    end
    tests++;
    if ({float_out, out_tag, float_out_underflow, float_out_overflow} !== {24'h452C30, 4'd5, 2'b00}) begin
      fails++;
      $display("FAIL basic_product: got %h tag %h uf%b of%b expected 452c30 tag 5 no flags",
               float_out, out_tag, float_out_underflow, float_out_overflow);
    end
    @(posedge clk);
    #1;
    run_op(24'hC00000, 24'h3F8000, 4'd9, r, rt, uf, of, ok);
    tests++;
    if ({ok, r, rt, uf, of} !== {1'b1, 24'hC08000, 4'd9, 2'b00}) begin
      fails++;
      $display("FAIL negative_product: got ok%b %h tag %h uf%b of%b expected c08000 tag 9",
               ok, r, rt, uf, of);
    end
  endtask

  task automatic test_overflow;
    logic [23:0] r;
    logic [3:0]  rt;
    logic        uf, of, ok;
    run_op(24'h7F0000, 24'h400000, 4'd2, r, rt, uf, of, ok);
    tests++;
    if ({ok, r, uf, of} !== {1'b1, 24'h7FFFFF, 2'b01}) begin
      fails++;
      $display("FAIL overflow_pos: got ok%b %h uf%b of%b expected 7fffff of=1", ok, r, uf, of);
    end
    tests++;
    if (sticky_flags !== 2'b10) begin
      fails++;
      $display("FAIL sticky_of: got %b expected 10", sticky_flags);
    end
    run_op(24'hFF0000, 24'h400000, 4'd3, r, rt, uf, of, ok);
    tests++;
    if ({ok, r, uf, of} !== {1'b1, 24'hFFFFFF, 2'b01}) begin
      fails++;
      $display("FAIL overflow_neg: got ok%b %h uf%b of%b expected ffffff of=1", ok, r, uf, of);
    end
    run_op(24'h7F0000, 24'h3F0000, 4'd4, r, rt, uf, of, ok);
    tests++;
    if ({ok, r, uf, of} !== {1'b1, 24'h7F0000, 2'b00}) begin
      fails++;
      $display("FAIL exp_max_edge: got ok%b %h uf%b of%b expected 7f0000 no flags", ok, r, uf, of);
    end
    tests++;
    if (sticky_flags !== 2'b10) begin
      fails++;
      $display("FAIL sticky_hold: got %b expected 10", sticky_flags);
    end
    flag_clr = 1'b1;
    @(posedge clk);
    #1 flag_clr = 1'b0;
    tests++;
    if (sticky_flags !== 2'b00) begin
      fails++;
      $display("FAIL sticky_clear: got %b expected 00", sticky_flags);
    end
  endtask

  task automatic test_underflow_zero;
    logic [23:0] r;
    logic [3:0]  rt;
    logic        uf, of, ok;
    run_op(24'h010000, 24'h010000, 4'd1, r, rt, uf, of, ok);
    tests++;
    if ({ok, r, uf, of} !== {1'b1, 24'h000000, 2'b10}) begin
      fails++;
      $display("FAIL underflow: got ok%b %h uf%b of%b expected 000000 uf=1", ok, r, uf, of);
    end
    tests++;
    if (sticky_flags !== 2'b01) begin
      fails++;
      $display("FAIL sticky_uf: got %b expected 01", sticky_flags);
    end
    run_op(24'h000000, 24'h3E0000, 4'd6, r, rt, uf, of, ok);
    tests++;
    if ({ok, r, uf, of} !== {1'b1, 24'h000000, 2'b00}) begin
      fails++;
      $display("FAIL zero_operand: got ok%b %h uf%b of%b expected 000000 no flags", ok, r, uf, of);
    end
    run_op(24'hBE0000, 24'h800000, 4'd7, r, rt, uf, of, ok);
    tests++;
    if ({ok, r, uf, of} !== {1'b1, 24'h000000, 2'b00}) begin
      fails++;
      $display("FAIL signed_zero: got ok%b %h uf%b of%b expected 000000 no flags", ok, r, uf, of);
    end
    run_op(24'h200000, 24'h200000, 4'd8, r, rt, uf, of, ok);
    tests++;
    if ({ok, r, uf, of} !== {1'b1, 24'h010000, 2'b00}) begin
      fails++;
      $display("FAIL exp_min_edge: got ok%b %h uf%b of%b expected 010000 no flags", ok, r, uf, of);
    end
  endtask

  task automatic test_clear_wins;
    logic ok_in, ok_out;
    flag_clr = 1'b1;
    @(posedge clk);
    #1 flag_clr = 1'b0;
    issue(24'h7F0000, 24'h400000, 4'd2, ok_in);
    wait_out(ok_out);
    flag_clr = 1'b1;
    @(posedge clk);
    #1 flag_clr = 1'b0;
    tests++;
    if ({ok_in, ok_out, sticky_flags} !== {2'b11, 2'b00}) begin
      fails++;
      $display("FAIL clear_wins: got ok%b%b sticky=%b expected sticky 00", ok_in, ok_out, sticky_flags);
    end
  endtask

  task automatic test_rounding;
    logic [23:0] r;
    logic [23:0] exp_r;
    logic [3:0]  rt;
    logic        uf, of, ok;
`ifdef FMUL_RNE_EN
    exp_r = 24'h3F8002;
`else
    exp_r = 24'h3F8001;
`endif
    run_op(24'h3F0001, 24'h3F8000, 4'd10, r, rt, uf, of, ok);
    tests++;
    if ({ok, r} !== {1'b1, exp_r}) begin
      fails++;
      $display("FAIL rounding_tie: got ok%b %h expected %h", ok, r, exp_r);
    end
  endtask

  task automatic test_back_to_back;
    int         acc;
    int         nr;
    logic       rdy;
    logic [3:0] rcv[8];
    out_ready = 1'b0;
    acc       = 0;
    nr        = 0;
    float_a   = 24'h3F0000;
    float_b   = 24'h3F0000;
    in_tag    = 4'd0;
    in_valid  = 1'b1;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc++;
        in_tag = 4'(acc);
      end
    end
    @(negedge clk);
    tests++;
    if ({acc == 3, in_ready, out_valid, out_tag} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
      fails++;
      $display("FAIL bp_full: got acc=%0d in_ready=%b out_valid=%b tag=%h expected acc=3 ready=0 valid=1 tag=0",
               acc, in_ready, out_valid, out_tag);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, out_tag, float_out} !== {1'b0, 1'b1, 4'd0, 24'h3F0000}) begin
      fails++;
      $display("FAIL bp_hold: got ready=%b valid=%b tag=%h out=%h expected 0 1 0 3f0000",
               in_ready, out_valid, out_tag, float_out);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (nr < 8) rcv[nr] = out_tag;
        nr++;
      end
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (in_valid && rdy) begin
        acc++;
        if (acc == 5) in_valid = 1'b0;
        else in_tag = 4'(acc);
      end
    end
    tests++;
    if (nr !== 5) begin
      fails++;
      $display("FAIL bp_count: got %0d results expected 5", nr);
    end
    for (int i = 0; i < 5 && i < nr; i++) begin
      tests++;
      if (rcv[i] !== 4'(i)) begin
        fails++;
        $display("FAIL bp_order[%0d]: got tag %h expected %h", i, rcv[i], 4'(i));
      end
    end
  endtask

  task automatic test_reset_midstream;
    logic stale;
    out_ready = 1'b1;
    float_a   = 24'h3F0000;
    float_b   = 24'h3F0000;
    in_tag    = 4'd7;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_tag = 4'd8;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #3;
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre: got out_valid=%b expected 1", out_valid);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_immediate: got out_valid=%b expected 0", out_valid);
    end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    tests++;
    if (stale !== 1'b0) begin
      fails++;
      $display("FAIL rst_stale: got stale result=%b expected 0", stale);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    float_a   = '0;
    float_b   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    flag_clr  = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_underflow_zero();
    test_clear_wins();
    test_rounding();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
